// File: rtl/parallel_mac_collector.sv
// Lane-parallel signed MAC collector: accumulates N products over M steps, then drains one lane per handshake.
// Optional MAC_COLLECTOR_RELU_EN clamps negative results to zero at the output only.
module parallel_mac_collector #(
  parameter int Width = 8,
  parameter int N     = 4,
  parameter int M     = 3,
  localparam int SCW  = $clog2(M + 1),
  localparam int LW   = (N > 1) ? $clog2(N) : 1,
  localparam int AccW = 2 * Width + $clog2(M + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [N*Width-1:0]   a_vec,
  input  logic [N*Width-1:0]   b_vec,
  output logic [SCW-1:0]       step_cnt,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LW-1:0]        out_lane,
  output logic [AccW-1:0]      out_data,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                 state_reg;
  logic signed [AccW-1:0] acc_reg [N];
  logic signed [AccW-1:0] sel_acc;
  logic                   clear_acc;
  logic                   step_en;

  assign clear_acc = (state_reg == IDLE) && start;
  assign step_en   = (state_reg == ACCUM) && in_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic signed [Width-1:0]   a_lane;
      logic signed [Width-1:0]   b_lane;
      logic signed [2*Width-1:0] prod;

      assign a_lane = a_vec[gi*Width +: Width];
      assign b_lane = b_vec[gi*Width +: Width];
      assign prod   = a_lane * b_lane;

      // Headroom bits above the product width cover M additions without wrap.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg[gi] <= '0;
        end else if (clear_acc) begin
          acc_reg[gi] <= '0;
        end else if (step_en) begin
          acc_reg[gi] <= acc_reg[gi] + {{(AccW-2*Width){prod[2*Width-1]}}, prod};
        end
      end
    end
  endgenerate

  assign sel_acc = acc_reg[out_lane];

`ifdef MAC_COLLECTOR_RELU_EN
  assign out_data = sel_acc[AccW-1] ? '0 : sel_acc;
`else
  assign out_data = sel_acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      step_cnt  <= '0;
      out_lane  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= ACCUM;
            step_cnt  <= '0;
            busy      <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            step_cnt <= step_cnt + 1'b1;
            if (step_cnt == SCW'(M - 1)) begin
              state_reg <= DRAIN;
              out_lane  <= '0;
              out_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_lane == LW'(N - 1)) begin
              state_reg <= IDLE;
              out_lane  <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
            end else begin
              out_lane <= out_lane + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
